fp_mult_pipe_simd: RTL and testbench



---
 rtl/fp_mult_pipe_simd.sv | 268 ++++++++++++++++++++++++++
 tb/tb_fp_mult_pipe_simd.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mult_pipe_simd.sv
// -----------------------------------------------------------------------------
// fp_mult_pipe_simd : LANES-wide IEEE-754 binary32 multiplier, PIPE_STAGES deep.
//
// One valid/ready handshake is shared by all lanes. The pipe advances as a unit
// (adv = !out_valid || out_ready), so in_ready = adv and the whole pipe freezes
// on a stall. A sideband tag rides alongside each beat.
//
// Arithmetic: denormal inputs flush to signed zero, round to nearest even,
// results with biased exponent outside 1..254 (after rounding) become signed
// Inf / signed zero. NaN or Inf*0 yields 0x7FC00000.
//
// Build option: define FP_MULT_FLAGS_EN to add out_flags, per lane
// {invalid, overflow, underflow, inexact}. Data results do not depend on it.
//
// Ports:
//   clk        in   clock, rising edge
//   aclr_n     in   asynchronous active-low reset
//   in_valid   in   input beat valid
//   in_ready   out  beat accepted this cycle when in_valid is high
//   in_ay      in   operand A, lane i at [32i+31:32i]
//   in_az      in   operand B, same packing
//   in_tag     in   sideband tag
//   out_valid  out  result beat valid
//   out_ready  in   downstream accepts result beat
//   out_result out  products, same packing
//   out_tag    out  tag of the beat on out_result
//   out_flags  out  per-lane flags, 4 bits per lane (FP_MULT_FLAGS_EN only)
// -----------------------------------------------------------------------------

// One multiply lane. Holds its own data registers; the valid/tag pipe lives in
// the top. Stage 1 registers the raw 48-bit significand product when
// PIPE_STAGES > 1; normalise/round sits after it and the remaining stages are
// plain delay registers on the rounded result.
module fp_mult_lane #(
    parameter int PIPE_STAGES = 3
) (
    input  logic        clk,
    input  logic        aclr_n,
    input  logic        adv,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result
`ifdef FP_MULT_FLAGS_EN
    ,
    output logic [3:0]  flags
`endif
);
    typedef enum logic [1:0] {CLS_NORM, CLS_ZERO, CLS_INF, CLS_NAN} cls_e;

    typedef struct packed {
        logic        sign;
        cls_e        cls;
        logic [9:0]  exp;   // two's complement, eA + eB - 127
        logic [47:0] prod;
    } prod_t;

    localparam int TAIL = (PIPE_STAGES > 1) ? PIPE_STAGES - 1 : 1;

    prod_t       p_d, p_q;
    logic [7:0]  ea, eb;
    logic        a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;

    // ---- unpack, classify, multiply ----
    always_comb begin
        ea     = a[30:23];
        eb     = b[30:23];
        a_nan  = (ea == 8'hFF) && (a[22:0] != 23'd0);
        a_inf  = (ea == 8'hFF) && (a[22:0] == 23'd0);
        a_zero = (ea == 8'h00);   // denormals flush to zero here
        b_nan  = (eb == 8'hFF) && (b[22:0] != 23'd0);
        b_inf  = (eb == 8'hFF) && (b[22:0] == 23'd0);
        b_zero = (eb == 8'h00);

        p_d.sign = a[31] ^ b[31];
        p_d.exp  = {2'b00, ea} + {2'b00, eb} - 10'd127;
        p_d.prod = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};

        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
            p_d.cls = CLS_NAN;
        else if (a_inf || b_inf)
            p_d.cls = CLS_INF;
        else if (a_zero || b_zero)
            p_d.cls = CLS_ZERO;
        else
            p_d.cls = CLS_NORM;
    end

    generate
        if (PIPE_STAGES > 1) begin : g_prod_reg
            always_ff @(posedge clk or negedge aclr_n) begin
                if (!aclr_n)
                    p_q <= '0;
                else if (adv)
                    p_q <= p_d;
            end
        end else begin : g_prod_comb
            always_comb p_q = p_d;
        end
    endgenerate

    // ---- normalise and round ----
    logic               hi;
    logic [22:0]        frac;
    logic               guard, sticky, rnd_up;
    logic [24:0]        sig;
    logic signed [10:0] e_r;
    logic [31:0]        res_d;
`ifdef FP_MULT_FLAGS_EN
    logic [3:0]         flg_d;
`endif

    always_comb begin
        hi = p_q.prod[47];   // product in [2,4): one right shift
        if (hi) begin
            frac   = p_q.prod[46:24];
            guard  = p_q.prod[23];
            sticky = |p_q.prod[22:0];
        end else begin
            frac   = p_q.prod[45:23];
            guard  = p_q.prod[22];
            sticky = |p_q.prod[21:0];
        end
        rnd_up = guard & (sticky | frac[0]);
        // sig[24] set only when 1.111..1 rounds up to 2.0; frac bits are then 0
        sig = {2'b01, frac} + {24'd0, rnd_up};
        e_r = $signed({p_q.exp[9], p_q.exp}) + 11'(hi) + 11'(sig[24]);

        res_d = {p_q.sign, e_r[7:0], sig[22:0]};
`ifdef FP_MULT_FLAGS_EN
        flg_d = {3'b000, guard | sticky};
`endif
        if (e_r > 11'sd254) begin
            res_d = {p_q.sign, 8'hFF, 23'd0};
`ifdef FP_MULT_FLAGS_EN
            flg_d = 4'b0101;
`endif
        end else if (e_r < 11'sd1) begin
            res_d = {p_q.sign, 31'd0};
`ifdef FP_MULT_FLAGS_EN
            flg_d = 4'b0011;
`endif
        end

        case (p_q.cls)
            CLS_NAN: begin
                res_d = 32'h7FC0_0000;
`ifdef FP_MULT_FLAGS_EN
                flg_d = 4'b1000;
`endif
            end
            CLS_INF: begin
                res_d = {p_q.sign, 8'hFF, 23'd0};
`ifdef FP_MULT_FLAGS_EN
                flg_d = 4'b0000;
`endif
            end
            CLS_ZERO: begin
                res_d = {p_q.sign, 31'd0};
`ifdef FP_MULT_FLAGS_EN
                flg_d = 4'b0000;
`endif
            end
            default: ;
        endcase
    end

    // ---- output delay stages ----
    logic [TAIL-1:0][31:0] res_pipe;

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            res_pipe <= '0;
        end else if (adv) begin
            res_pipe[0] <= res_d;
            for (int k = 1; k < TAIL; k++)
                res_pipe[k] <= res_pipe[k-1];
        end
    end

    assign result = res_pipe[TAIL-1];

`ifdef FP_MULT_FLAGS_EN
    logic [TAIL-1:0][3:0] flg_pipe;

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            flg_pipe <= '0;
        end else if (adv) begin
            flg_pipe[0] <= flg_d;
            for (int k = 1; k < TAIL; k++)
                flg_pipe[k] <= flg_pipe[k-1];
        end
    end

    assign flags = flg_pipe[TAIL-1];
`endif
endmodule

module fp_mult_pipe_simd #(
    parameter int LANES       = 4,
    parameter int PIPE_STAGES = 3,   // 1..6
    parameter int TAG_W       = 8
) (
    input  logic                  clk,
    input  logic                  aclr_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [32*LANES-1:0]   in_ay,
    input  logic [32*LANES-1:0]   in_az,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [32*LANES-1:0]   out_result,
    output logic [TAG_W-1:0]      out_tag
`ifdef FP_MULT_FLAGS_EN
    ,
    output logic [4*LANES-1:0]    out_flags
`endif
);
    logic                              adv;
    logic [PIPE_STAGES:1]              vld_pipe;
    logic [PIPE_STAGES:1][TAG_W-1:0]   tag_pipe;
    logic [LANES-1:0][31:0]            ay_l, az_l, res_l;

    // Pipe moves whenever the output slot is empty or being drained.
    assign adv       = !vld_pipe[PIPE_STAGES] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_pipe[PIPE_STAGES];
    assign out_tag   = tag_pipe[PIPE_STAGES];

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            vld_pipe <= '0;
            tag_pipe <= '0;
        end else if (adv) begin
            vld_pipe[1] <= in_valid;
            tag_pipe[1] <= in_tag;
            for (int k = 2; k <= PIPE_STAGES; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                tag_pipe[k] <= tag_pipe[k-1];
            end
        end
    end

    assign ay_l       = in_ay;
    assign az_l       = in_az;
    assign out_result = res_l;

`ifdef FP_MULT_FLAGS_EN
    logic [LANES-1:0][3:0] flg_l;
    assign out_flags = flg_l;
`endif

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        fp_mult_lane #(.PIPE_STAGES(PIPE_STAGES)) u_lane (
            .clk    (clk),
            .aclr_n (aclr_n),
            .adv    (adv),
            .a      (ay_l[i]),
            .b      (az_l[i]),
            .result (res_l[i])
`ifdef FP_MULT_FLAGS_EN
            ,
            .flags  (flg_l[i])
`endif
        );
    end
endmodule

// File: tb/tb_fp_mult_pipe_simd.sv
// Bench for fp_mult_pipe_simd: main instance (LANES=4, PIPE_STAGES=3) driven by
// directed and random beats against a real-arithmetic reference model, plus a
// PIPE_STAGES=1 instance for the single-cycle latency case.
module tb_fp_mult_pipe_simd;
    localparam int LANES = 4;
    localparam int PS    = 3;
    localparam int TAG_W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 aclr_n;
    logic                 in_valid, in_ready, out_valid, out_ready;
    logic [32*LANES-1:0]  in_ay, in_az, out_result;
    logic [TAG_W-1:0]     in_tag, out_tag;
    logic                 in_valid1, in_ready1, out_valid1, out_ready1;
    logic [32*LANES-1:0]  out_result1;
    logic [TAG_W-1:0]     out_tag1;
`ifdef FP_MULT_FLAGS_EN
    logic [4*LANES-1:0]   out_flags, out_flags1;
`endif

    fp_mult_pipe_simd #(.LANES(LANES), .PIPE_STAGES(PS), .TAG_W(TAG_W)) dut (
        .clk(clk), .aclr_n(aclr_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_ay(in_ay), .in_az(in_az), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag)
`ifdef FP_MULT_FLAGS_EN
        , .out_flags(out_flags)
`endif
    );

    fp_mult_pipe_simd #(.LANES(LANES), .PIPE_STAGES(1), .TAG_W(TAG_W)) dut1 (
        .clk(clk), .aclr_n(aclr_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_ay(in_ay), .in_az(in_az), .in_tag(in_tag), .out_valid(out_valid1),
        .out_ready(out_ready1), .out_result(out_result1), .out_tag(out_tag1)
`ifdef FP_MULT_FLAGS_EN
        , .out_flags(out_flags1)
`endif
    );

    typedef struct {
        logic [32*LANES-1:0] res;
        logic [4*LANES-1:0]  flg;
        logic [TAG_W-1:0]    tag;
        int                  cyc;
    } exp_t;

    exp_t                sb[$];
    logic [TAG_W-1:0]    ret_tags[$];
    int                  n_chk = 0, n_fail = 0;
    int                  cyc = 0, last_lat = -1;
    logic                s_valid, s_ready, s_acc;
    logic [32*LANES-1:0] s_res, last_res, prev_res;
    logic [TAG_W-1:0]    s_tag, last_tag, prev_tag;
    logic [4*LANES-1:0]  last_flg;

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
        end
    endtask

    // Reference: exact significand product in double precision, rounded to a
    // 24-bit significand with an unbounded exponent, then range-checked.
    // Returns {invalid, overflow, underflow, inexact, result}.
    function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b);
        int     ea, eb, e;
        logic   s, a_nan, a_inf, a_zero, b_nan, b_inf, b_zero, inx;
        real    x, sc, fl, rem;
        longint q;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        s  = a[31] ^ b[31];
        a_nan = (ea == 255) && (a[22:0] != 0); a_inf = (ea == 255) && (a[22:0] == 0); a_zero = (ea == 0);
        b_nan = (eb == 255) && (b[22:0] != 0); b_inf = (eb == 255) && (b[22:0] == 0); b_zero = (eb == 0);
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return {4'b1000, 32'h7FC00000};
        if (a_inf || b_inf) return {4'b0000, s, 8'hFF, 23'd0};
        if (a_zero || b_zero) return {4'b0000, s, 31'd0};
        x = (1.0 + real'(a[22:0]) / 8388608.0) * (1.0 + real'(b[22:0]) / 8388608.0);
        e = ea + eb - 127;
        if (x >= 2.0) begin x = x / 2.0; e++; end
        sc  = x * 8388608.0;
        fl  = $floor(sc);
        rem = sc - fl;
        q   = longint'(fl);
        inx = (rem != 0.0);
        if (rem > 0.5 || (rem == 0.5 && q[0])) q++;
        if (q == 64'sd16777216) begin q = 8388608; e++; end
        if (e > 254) return {4'b0101, s, 8'hFF, 23'd0};
        if (e < 1)   return {4'b0011, s, 31'd0};
        return {3'b000, inx, s, 8'(e), 23'(q - 8388608)};
    endfunction

    function automatic logic [31:0] rnd_op();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 9))
            0:       v[30:23] = 8'hFF;
            1:       v[30:23] = 8'h00;
            2:       v[22:0]  = '1;
            3:       v[30:23] = 8'($urandom_range(180, 254));
            4:       v[30:23] = 8'($urandom_range(1, 70));
            default: v[30:23] = 8'($urandom_range(100, 154));
        endcase
        return v;
    endfunction

    task automatic rnd_beat();
        for (int i = 0; i < LANES; i++) begin
            in_ay[32*i +: 32] = rnd_op();
            in_az[32*i +: 32] = rnd_op();
        end
    endtask

    // One clock: sample handshakes at negedge, score retirements, record
    // accepted beats, then return 1 time unit after the rising edge.
    task automatic tick();
        exp_t     e;
        logic [35:0] m;
        @(negedge clk);
        cyc++;
        s_valid = out_valid; s_ready = in_ready; s_res = out_result; s_tag = out_tag;
        s_acc   = in_valid && in_ready;
        if (out_valid && out_ready) begin
            chk("beat_expected", 128'(sb.size() != 0), 128'(1));
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("result", out_result, e.res);
                chk("tag", out_tag, e.tag);
`ifdef FP_MULT_FLAGS_EN
                chk("flags", out_flags, e.flg);
                last_flg = out_flags;
`endif
                last_lat = cyc - e.cyc;
                last_res = out_result;
                last_tag = out_tag;
                ret_tags.push_back(out_tag);
            end
        end
        if (s_acc) begin
            for (int i = 0; i < LANES; i++) begin
                m = model(in_ay[32*i +: 32], in_az[32*i +: 32]);
                e.res[32*i +: 32] = m[31:0];
                e.flg[4*i +: 4]   = m[35:32];
            end
            e.tag = in_tag;
            e.cyc = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        chk(name, 128'(sb.size()), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        aclr_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_valid1 = 1'b0; out_ready1 = 1'b1;
        in_ay = '0; in_az = '0; in_tag = '0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_in_ready", in_ready, 1);
`ifdef FP_MULT_FLAGS_EN
        chk("rst_out_flags", out_flags, 0);
`endif
        #20;
        @(negedge clk); aclr_n = 1'b1;
        @(posedge clk); #1;

        // ---- basic multiply + specials, latency 3 ----
        in_valid = 1'b1; in_tag = 8'hA5;
        in_ay = {32'h7F7FFFFF, 32'h7F800000, 32'h3FC00000, 32'h40000000};
        in_az = {32'h40000000, 32'h00000000, 32'h3FC00000, 32'h40400000};
        tick();
        in_valid = 1'b0;
        tick(); chk("lat_early1", s_valid, 0);
        tick(); chk("lat_early2", s_valid, 0);
        tick(); chk("lat_on_time", s_valid, 1);
        chk("basic_latency", last_lat, PS);
        chk("basic_lane0", last_res[31:0], 32'h40C00000);
        chk("basic_lane1", last_res[63:32], 32'h40100000);
        chk("inf_x_zero", last_res[95:64], 32'h7FC00000);
        chk("overflow", last_res[127:96], 32'h7F800000);
        chk("basic_tag", last_tag, 8'hA5);
`ifdef FP_MULT_FLAGS_EN
        chk("flags_invalid", last_flg[11:8], 4'b1000);
        chk("flags_overflow", last_flg[15:12], 4'b0101);
`endif

        in_valid = 1'b1; in_tag = 8'h5A;
        in_ay = {32'h00800000, 32'hFF800000, 32'h3F800001, 32'h80000001};
        in_az = {32'h00800000, 32'h40000000, 32'h3F800001, 32'h3F800000};
        tick();
        in_valid = 1'b0;
        wait_drain("drain_specials");
        chk("denorm_in", last_res[31:0], 32'h80000000);
        chk("round_tie", last_res[63:32], 32'h3F800002);
        chk("neg_inf", last_res[95:64], 32'hFF800000);
        chk("underflow", last_res[127:96], 32'h00000000);
`ifdef FP_MULT_FLAGS_EN
        chk("flags_inexact", last_flg[7:4], 4'b0001);
        chk("flags_underflow", last_flg[15:12], 4'b0011);
`endif

        // ---- backpressure: 10 tags, 5-cycle stall mid-stream ----
        ret_tags.delete();
        sent = 0;
        for (int t = 0; t < 40; t++) begin
            out_ready = !(t >= 5 && t < 10);
            in_valid  = (sent < 10);
            in_tag    = 8'(sent);
            rnd_beat();
            tick();
            if (s_acc) sent++;
            if (t >= 5 && t < 10) begin
                chk("bp_in_ready", s_ready, 0);
                chk("bp_out_valid", s_valid, 1);
                if (t > 5) begin
                    chk("bp_hold_result", s_res, prev_res);
                    chk("bp_hold_tag", s_tag, prev_tag);
                end
            end
            prev_res = s_res; prev_tag = s_tag;
            if (sent == 10 && sb.size() == 0) break;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("bp_count", 128'(ret_tags.size()), 128'(10));
        for (int i = 0; i < ret_tags.size(); i++) chk("bp_order", ret_tags[i], 128'(i));

        // ---- reset with 3 beats in flight ----
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_tag = 8'(8'h40 + i); rnd_beat();
            tick();
        end
        in_valid = 1'b0;
        chk("rst_pre_valid", out_valid, 1);
        #2 aclr_n = 1'b0;
        #1;
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_result", out_result, 0);
        chk("rst_mid_tag", out_tag, 0);
        sb.delete();
        @(negedge clk); aclr_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rst_no_stale", s_valid, 0);
        end
        in_valid = 1'b1; in_tag = 8'h77; rnd_beat();
        tick();
        in_valid = 1'b0;
        wait_drain("rst_new_beat");
        chk("rst_latency", last_lat, PS);
        chk("rst_new_tag", last_tag, 8'h77);

        // ---- random traffic with random backpressure ----
        for (int t = 0; t < 400; t++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_tag    = 8'($urandom);
            rnd_beat();
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        wait_drain("random_drain");

        // ---- PIPE_STAGES = 1 instance: latency 1 ----
        in_ay = {32'h0, 32'h0, 32'h3FC00000, 32'h40000000};
        in_az = {32'h0, 32'h0, 32'h3FC00000, 32'h40400000};
        in_tag = 8'h3C; in_valid1 = 1'b1;
        @(negedge clk);
        chk("ps1_in_ready", in_ready1, 1);
        chk("ps1_idle", out_valid1, 0);
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        @(negedge clk);
        chk("ps1_valid", out_valid1, 1);
        chk("ps1_lane0", out_result1[31:0], 32'h40C00000);
        chk("ps1_lane1", out_result1[63:32], 32'h40100000);
        chk("ps1_tag", out_tag1, 8'h3C);
        @(posedge clk); #1;
        @(negedge clk);
        chk("ps1_retired", out_valid1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
